key_event_ctrl: RTL



---
 rtl/key_ctrl_pkg.sv | 10 +
 rtl/key_event_ctrl_timer.sv | 19 +
 rtl/key_event_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: PIO register offsets, controller states and the key-priority helper
package key_ctrl_pkg;
    localparam logic [1:0] PIO_DATA = 2'd0;
    localparam logic [1:0] PIO_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE = 2'd3;
    typedef enum logic [2:0] {W_MASK, W_INIT_CLR, IDLE, RD_CAP, RD_WAIT, CLR, DISPATCH, HOLD} state_t;
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
    endfunction
endpackage

// File: rtl/key_event_ctrl_timer.sv
// key_holdoff_timer: loadable down-counter with a zero flag for the irq hold-off window
module key_holdoff_timer #(
    parameter int W = 20,
    parameter logic [W-1:0] LOAD = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (load) count <= LOAD;
        else if (dec && !zero) count <= count - W'(1);
    end
    assign zero = count == '0;
endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: services the key PIO edge-capture irq and streams one key event per handshake
module key_event_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int NUM_KEYS = 3,
    parameter logic [NUM_KEYS-1:0] KEY_MASK = 3'b111,
    parameter int HOLDOFF_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        pio_irq,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_key,
    output logic        init_done,
    output logic        busy
);
    state_t state, state_next;
    logic [NUM_KEYS-1:0] pending, taken;
    logic fire, timer_zero, unused_readdata;
    assign unused_readdata = ^avm_readdata[31:NUM_KEYS];
    assign evt_valid = !reset && state == DISPATCH && pending != '0;
    assign evt_key = lowest_set(4'(pending));
    assign fire = evt_valid && evt_ready;
    assign taken = fire ? NUM_KEYS'(1) << evt_key : '0;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= W_MASK;
            pending <= '0;
            init_done <= 1'b0;
        end else begin
            state <= state_next;
            pending <= state == RD_WAIT ? pending | (avm_readdata[NUM_KEYS-1:0] & KEY_MASK) : pending & ~taken;
            if (state == W_INIT_CLR) init_done <= 1'b1;
        end
    end
    always_comb begin
        state_next = state;
        avm_chipselect = 1'b0;
        avm_write_n = 1'b1;
        avm_address = PIO_DATA;
        avm_writedata = '0;
        case (state)
            W_MASK: begin
                avm_chipselect = 1'b1;
                avm_write_n = 1'b0;
                avm_address = PIO_MASK;
                avm_writedata = 32'(KEY_MASK);
                state_next = W_INIT_CLR;
            end
            W_INIT_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n = 1'b0;
                avm_address = PIO_EDGE;
                state_next = IDLE;
            end
            IDLE: state_next = pio_irq && enable ? RD_CAP : IDLE;
            RD_CAP: begin
                avm_chipselect = 1'b1;
                avm_address = PIO_EDGE;
                state_next = RD_WAIT;
            end
            RD_WAIT: state_next = CLR;
            CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n = 1'b0;
                avm_address = PIO_EDGE;
                state_next = DISPATCH;
            end
            // leave as soon as the last event is accepted so hold-off starts next cycle
            DISPATCH: state_next = (pending & ~taken) == '0 ? HOLD : DISPATCH;
            HOLD: state_next = timer_zero ? IDLE : HOLD;
            default: state_next = W_MASK;
        endcase
        if (reset) begin
            avm_chipselect = 1'b0;
            avm_write_n = 1'b1;
            avm_address = PIO_DATA;
            avm_writedata = '0;
        end
    end
    key_holdoff_timer #(.W(20), .LOAD(20'(HOLDOFF_CYCLES))) u_timer (
        .clk(clk),
        .reset(reset),
        .load(state == DISPATCH && state_next == HOLD),
        .dec(state == HOLD),
        .zero(timer_zero)
    );
endmodule
